// File: rtl/md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer
//   Multi-cycle multiply/divide unit holding the HI/LO register pair.
//   An op is launched by a Start pulse from the E stage. The result is
//   computed from A/B (and, for the multiply-accumulate family, from the
//   current {HI,LO}) at the Start edge. It is parked in shadow registers,
//   and it is committed to HI/LO after a fixed latency.
//
//   Optional feature macro: MD_MADD_EN
//     defined   : MDOp 6..9 = madd/maddu/msub/msubu, latency MULT_CYCLES
//     undefined : MDOp 6..9 behave as reserved opcodes (no effect)
//
// Parameters
//   MULT_CYCLES  Busy cycles for multiply ops (1..15)
//   DIV_CYCLES   Busy cycles for divide ops   (1..15)
//
// Ports
//   clk    in   pipeline clock
//   reset  in   synchronous, active-high reset
//   Start  in   op-valid pulse, qualifies MDOp/A/B
//   MDOp   in   [3:0] opcode: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo,
//               6 madd, 7 maddu, 8 msub, 9 msubu, 10-15 reserved
//   A, B   in   [31:0] rs / rt operands
//   Busy   out  high while a multi-cycle op is in flight
//   Done   out  one-cycle pulse in the first cycle after HI/LO commit
//   HI, LO out  [31:0] architectural HI/LO registers
// ---------------------------------------------------------------------------
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // The countdown is loaded with N-1 so the commit edge lands N edges after Start.
  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES - 1);

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [31:0] hi_reg, lo_reg;
  logic [31:0] hi_n_reg, lo_n_reg;   // pending result, committed at the end
  logic        wr_reg;               // pending result is valid (cleared by divide-by-zero)
  logic        done_reg;

  // ---------------- result datapath ----------------
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide is done on magnitudes, then signs are restored. This way
  // 0x80000000 / -1 wraps cleanly to 0x80000000 with remainder 0.
  logic        div_signed;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, q_res, r_res;
  always_comb begin
    div_signed = ~MDOp[0];
    a_mag  = (div_signed && A[31]) ? -A : A;
    b_mag  = (div_signed && B[31]) ? -B : B;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;   // result discarded when B==0
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    q_res  = (div_signed && (A[31] ^ B[31])) ? -q_mag : q_mag;
    r_res  = (div_signed && A[31]) ? -r_mag : r_mag;   // remainder follows dividend
  end

`ifdef MD_MADD_EN
  // Odd opcodes (7, 9) are unsigned, and bit 3 (8, 9) selects subtract.
  logic [63:0] madd_prod, madd_res;
  always_comb begin
    madd_prod = MDOp[0] ? prod_u : prod_s;
    madd_res  = MDOp[3] ? ({hi_reg, lo_reg} - madd_prod)
                        : ({hi_reg, lo_reg} + madd_prod);
  end
`endif

  // ---------------- sequencer ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      hi_n_reg  <= 32'd0;
      lo_n_reg  <= 32'd0;
      wr_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Start) begin
            case (MDOp)
              4'd0: begin
                state_reg              <= BUSY;
                cnt_reg                <= MULT_CNT;
                {hi_n_reg, lo_n_reg}   <= prod_s;
                wr_reg                 <= 1'b1;
              end
              4'd1: begin
                state_reg              <= BUSY;
                cnt_reg                <= MULT_CNT;
                {hi_n_reg, lo_n_reg}   <= prod_u;
                wr_reg                 <= 1'b1;
              end
              4'd2, 4'd3: begin
                state_reg <= BUSY;
                cnt_reg   <= DIV_CNT;
                hi_n_reg  <= r_res;
                lo_n_reg  <= q_res;
                wr_reg    <= (B != 32'd0);
              end
              4'd4: hi_reg <= A;
              4'd5: lo_reg <= A;
`ifdef MD_MADD_EN
              4'd6, 4'd7, 4'd8, 4'd9: begin
                state_reg              <= BUSY;
                cnt_reg                <= MULT_CNT;
                {hi_n_reg, lo_n_reg}   <= madd_res;
                wr_reg                 <= 1'b1;
              end
`endif
              default: ;
            endcase
          end
        end
        BUSY: begin
          // Start is ignored in this state, including on the commit edge.
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            if (wr_reg) begin
              hi_reg <= hi_n_reg;
              lo_reg <= lo_n_reg;
            end
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign Busy = (state_reg == BUSY);
  assign Done = done_reg;
  assign HI   = hi_reg;
  assign LO   = lo_reg;

endmodule

// File: tb/tb_md_sequencer.sv
// ---------------------------------------------------------------------------
// tb_md_sequencer
//   Directed stimulus for md_sequencer. A behavioural model tracks HI/LO and
//   the remaining busy cycles, and it is checked against the DUT every cycle.
//   Literal expectations at key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_md_sequencer;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, Start;
  logic [3:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  always #5 clk = ~clk;

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .Done  (Done),
    .HI    (HI),
    .LO    (LO)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // model state
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          p_wr = 1'b0;
  int          left = 0;      // busy cycles still to be shown
  bit          m_done = 1'b0;

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", n, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, rr;
    logic [63:0] acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (r) begin
      m_hi = '0; m_lo = '0; left = 0; m_done = 1'b0;
      return;
    end
    m_done = 1'b0;
    if (left > 0) begin
      left--;
      if (left == 0) begin
        if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
        m_done = 1'b1;
      end
    end else if (s) begin
      case (op)
        4'd0: begin acc = 64'(sa * sb); {p_hi, p_lo} = acc; p_wr = 1; left = MC; end
        4'd1: begin acc = {32'd0, a} * {32'd0, b}; {p_hi, p_lo} = acc; p_wr = 1; left = MC; end
        4'd2: begin
          if (b != 0) begin q = sa / sb; rr = sa % sb; p_lo = q[31:0]; p_hi = rr[31:0]; p_wr = 1; end
          else p_wr = 0;
          left = DC;
        end
        4'd3: begin
          if (b != 0) begin p_lo = a / b; p_hi = a % b; p_wr = 1; end
          else p_wr = 0;
          left = DC;
        end
        4'd4: m_hi = a;
        4'd5: m_lo = a;
`ifdef MD_MADD_EN
        4'd6: begin acc = {m_hi, m_lo} + 64'(sa * sb);              {p_hi, p_lo} = acc; p_wr = 1; left = MC; end
        4'd7: begin acc = {m_hi, m_lo} + ({32'd0, a} * {32'd0, b}); {p_hi, p_lo} = acc; p_wr = 1; left = MC; end
        4'd8: begin acc = {m_hi, m_lo} - 64'(sa * sb);              {p_hi, p_lo} = acc; p_wr = 1; left = MC; end
        4'd9: begin acc = {m_hi, m_lo} - ({32'd0, a} * {32'd0, b}); {p_hi, p_lo} = acc; p_wr = 1; left = MC; end
`endif
        default: ;
      endcase
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    reset = r; Start = s; MDOp = op; A = a; B = b;
    @(posedge clk);
    model_step(r, s, op, a, b);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", {31'd0, Busy}, {31'd0, (left > 0)});
      cmp("done", {31'd0, Done}, {31'd0, m_done});
      cmp("hi",   HI, m_hi);
      cmp("lo",   LO, m_lo);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Start = 1'b0; MDOp = 4'd0; A = '0; B = '0;
    tick(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    tick(1, 0, 0, 0, 0);
    cmp("rst_busy", {31'd0, Busy}, 32'd0);
    cmp("rst_hi", HI, 32'd0);
    cmp("rst_lo", LO, 32'd0);

    // mult -2 * 3
    tick(0, 1, 4'd0, 32'hFFFF_FFFE, 32'd3);
    idle(4);
    cmp("mult_busy_last", {31'd0, Busy}, 32'd1);
    idle(1);
    cmp("mult_done", {31'd0, Done}, 32'd1);
    cmp("mult_hi", HI, 32'hFFFF_FFFF);
    cmp("mult_lo", LO, 32'hFFFF_FFFA);
    idle(1);
    cmp("mult_done_pulse", {31'd0, Done}, 32'd0);

    // multu max * max
    tick(0, 1, 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(5);
    cmp("multu_hi", HI, 32'hFFFF_FFFE);
    cmp("multu_lo", LO, 32'h0000_0001);

    // div -7 / 2
    tick(0, 1, 4'd2, 32'hFFFF_FFF9, 32'd2);
    idle(10);
    cmp("div_lo", LO, 32'hFFFF_FFFD);
    cmp("div_hi", HI, 32'hFFFF_FFFF);

    // divu by zero keeps HI/LO
    tick(0, 1, 4'd3, 32'd7, 32'd0);
    idle(9);
    cmp("div0_busy", {31'd0, Busy}, 32'd1);
    idle(1);
    cmp("div0_done", {31'd0, Done}, 32'd1);
    cmp("div0_hi", HI, 32'hFFFF_FFFF);
    cmp("div0_lo", LO, 32'hFFFF_FFFD);

    // mthi / mtlo back to back
    tick(0, 1, 4'd4, 32'h1234_5678, 32'd0);
    cmp("mthi_hi", HI, 32'h1234_5678);
    cmp("mthi_busy", {31'd0, Busy}, 32'd0);
    tick(0, 1, 4'd5, 32'h0000_0009, 32'd0);
    cmp("mtlo_lo", LO, 32'h0000_0009);

    // Start while busy is ignored
    tick(0, 1, 4'd0, 32'h10, 32'h20);
    tick(0, 1, 4'd2, 32'd100, 32'd7);
    idle(4);
    cmp("ign_done", {31'd0, Done}, 32'd1);
    cmp("ign_hi", HI, 32'd0);
    cmp("ign_lo", LO, 32'h200);

    // reset during a divide
    tick(0, 1, 4'd2, 32'd100, 32'd7);
    idle(3);
    tick(1, 0, 0, 0, 0);
    cmp("rstmid_busy", {31'd0, Busy}, 32'd0);
    cmp("rstmid_done", {31'd0, Done}, 32'd0);
    cmp("rstmid_lo", LO, 32'd0);
    idle(10);

    // Start on the commit edge is ignored
    tick(0, 1, 4'd3, 32'd100, 32'd7);
    idle(9);
    tick(0, 1, 4'd0, 32'd5, 32'd5);
    cmp("cedge_done", {31'd0, Done}, 32'd1);
    cmp("cedge_busy", {31'd0, Busy}, 32'd0);
    cmp("cedge_hi", HI, 32'd2);
    cmp("cedge_lo", LO, 32'd14);
    idle(6);
    cmp("cedge_lo_kept", LO, 32'd14);

    // overflow divide wraps
    tick(0, 1, 4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(10);
    cmp("ovf_lo", LO, 32'h8000_0000);
    cmp("ovf_hi", HI, 32'd0);

    // reserved opcode
    tick(0, 1, 4'd12, 32'hDEAD_BEEF, 32'd1);
    cmp("rsv_busy", {31'd0, Busy}, 32'd0);
    cmp("rsv_hi", HI, 32'd0);

    // multiply-accumulate family
    tick(0, 1, 4'd4, 32'd0, 32'd0);
    tick(0, 1, 4'd5, 32'hFFFF_FFFF, 32'd0);
    tick(0, 1, 4'd7, 32'd1, 32'd1);
    idle(5);
`ifdef MD_MADD_EN
    cmp("maddu_hi", HI, 32'd1);
    cmp("maddu_lo", LO, 32'd0);
    tick(0, 1, 4'd8, 32'd2, 32'd3);
    idle(5);
    cmp("msub_hi", HI, 32'd0);
    cmp("msub_lo", LO, 32'hFFFF_FFFA);
`else
    cmp("maddu_off_busy", {31'd0, Busy}, 32'd0);
    cmp("maddu_off_hi", HI, 32'd0);
    cmp("maddu_off_lo", LO, 32'hFFFF_FFFF);
`endif
    idle(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
